median_window_ctrl: RTL

// - AXI4-Stream front-end and sequencer for median_processing_3x3.
// - Accepts a raster pixel stream and tracks column/row position.
// - Holds two line buffers and a 3x3 window.
// - Drives the kernel, data-valid and start-of-frame inputs of the median core.
// - Only fully-interior windows are emitted (no border padding).

---
 rtl/median_window_ctrl_if.sv | 27 ++
 rtl/median_window_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/median_window_ctrl_if.sv
// AXI4-Stream pixel bus feeding median_window_ctrl.
// The master drives pixels; the slave (the window controller) returns tready.
interface median_window_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;
  logic                  tlast;

  modport master (
    output tdata,
    output tvalid,
    output tuser,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tuser,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/median_window_ctrl.sv
// median_window_ctrl: AXI4-Stream front-end and sequencer for median_processing_3x3.
// Tracks raster position, keeps two line buffers and a 3x3 window, and emits one
// registered window per fully-interior pixel (no border padding).
// Optional feature: define MEDIAN_CTRL_STATS_EN to add o_kernel_count, the number of
// windows emitted in the last completed frame.
module median_window_ctrl #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned KERNEL_SIZE  = 3,
  parameter int unsigned IMAGE_WIDTH  = 10,
  parameter int unsigned IMAGE_HEIGHT = 6
) (
  input  logic                                 clk,
  input  logic                                 aresetn,
  median_window_ctrl_if.slave                  s_axis,
  output logic [0:2][0:2][DATA_WIDTH-1:0]      o_image_kernel_buffer,
  output logic                                 o_image_data_valid,
  output logic                                 o_start_of_frame,
  output logic                                 o_frame_done,
  output logic                                 o_line_err
`ifdef MEDIAN_CTRL_STATS_EN
  ,
  output logic [15:0]                          o_kernel_count
`endif
);

  localparam int unsigned ColW = $clog2(IMAGE_WIDTH);
  localparam int unsigned RowW = $clog2(IMAGE_HEIGHT);
  localparam logic [ColW-1:0] ColLast = ColW'(IMAGE_WIDTH - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMAGE_HEIGHT - 1);

  if (KERNEL_SIZE != 3) begin : g_bad_kernel
    $error("median_window_ctrl: only KERNEL_SIZE=3 is supported");
  end

  typedef enum logic [0:0] {StWaitSof, StRun} state_e;
  typedef logic [0:2][0:2][DATA_WIDTH-1:0] win_t;

  state_e                state_q;
  logic [ColW-1:0]       col_q;
  logic [RowW-1:0]       row_q;
  logic                  tready_q;
  logic [DATA_WIDTH-1:0] lbuf0_q [IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0] lbuf1_q [IMAGE_WIDTH];
  win_t                  win_q;
  win_t                  kern_q;
  logic                  valid_q;
  logic                  sof_q;
  logic                  done_q;
  logic                  err_q;

  logic                  accept;
  logic                  sof_beat;
  logic                  pix;
  logic                  restart;
  logic [ColW-1:0]       eff_col;
  logic [RowW-1:0]       eff_row;
  logic                  at_last_col;
  logic                  line_err;
  logic                  wrap;
  logic                  eof;
  logic                  emit;
  win_t                  win_shift;

  // Decode the accepted beat: position it lands on, errors, window emission.
  always_comb begin
    accept      = s_axis.tvalid & tready_q;
    sof_beat    = accept & s_axis.tuser;
    // In WAIT_SOF only a tuser beat counts as a pixel; everything else is dropped.
    pix         = accept & ((state_q == StRun) | s_axis.tuser);
    restart     = sof_beat & (state_q == StRun) & ((col_q != '0) | (row_q != '0));
    // A tuser beat is always pixel (0,0), whatever the counters say.
    eff_col     = sof_beat ? '0 : col_q;
    eff_row     = sof_beat ? '0 : row_q;
    at_last_col = (eff_col == ColLast);
    line_err    = restart |
                  (pix & s_axis.tlast & ~at_last_col) |
                  (pix & ~s_axis.tlast & at_last_col);
    // tuser wins over tlast: a start-of-frame beat never ends a line.
    wrap        = ~sof_beat & (s_axis.tlast | at_last_col);
    eof         = pix & (eff_row == RowLast) & at_last_col;
    emit        = pix & (eff_row >= RowW'(2)) & (eff_col >= ColW'(2));
  end

  // Window shifted left with the new column from the line buffers and the input.
  always_comb begin
    win_shift = win_q;
    for (int r = 0; r < 3; r++) begin
      win_shift[r][0] = win_q[r][1];
      win_shift[r][1] = win_q[r][2];
    end
    win_shift[0][2] = lbuf1_q[eff_col];
    win_shift[1][2] = lbuf0_q[eff_col];
    win_shift[2][2] = s_axis.tdata;
  end

  // Sequencer FSM, position counters, line buffers, window and registered outputs.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= StWaitSof;
      col_q    <= '0;
      row_q    <= '0;
      tready_q <= 1'b0;
      win_q    <= '0;
      kern_q   <= '0;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < int'(IMAGE_WIDTH); i++) begin
        lbuf0_q[i] <= '0;
        lbuf1_q[i] <= '0;
      end
    end else begin
      tready_q <= 1'b1;
      valid_q  <= emit;
      sof_q    <= emit & (eff_row == RowW'(2)) & (eff_col == ColW'(2));
      done_q   <= eof;
      err_q    <= line_err;
      if (pix) begin
        win_q            <= win_shift;
        lbuf1_q[eff_col] <= lbuf0_q[eff_col];
        lbuf0_q[eff_col] <= s_axis.tdata;
        if (eof) begin
          state_q <= StWaitSof;
          col_q   <= '0;
          row_q   <= '0;
        end else begin
          state_q <= StRun;
          if (wrap) begin
            col_q <= '0;
            row_q <= eff_row + 1'b1;
          end else begin
            col_q <= eff_col + 1'b1;
            row_q <= eff_row;
          end
        end
      end
      if (emit) begin
        kern_q <= win_shift;
      end
    end
  end

  assign s_axis.tready         = tready_q;
  assign o_image_kernel_buffer = kern_q;
  assign o_image_data_valid    = valid_q;
  assign o_start_of_frame      = sof_q;
  assign o_frame_done          = done_q;
  assign o_line_err            = err_q;

`ifdef MEDIAN_CTRL_STATS_EN
  logic [15:0] kcnt_q;
  logic [15:0] kcnt_d;
  logic [15:0] kstat_q;

  // Running window count; any start-of-frame beat (clean or restart) clears it.
  always_comb begin
    kcnt_d = kcnt_q;
    if (sof_beat) begin
      kcnt_d = '0;
    end else if (emit) begin
      kcnt_d = kcnt_q + 16'd1;
    end
  end

  // Count register and the per-frame snapshot that appears with o_frame_done.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      kcnt_q  <= '0;
      kstat_q <= '0;
    end else begin
      kcnt_q <= kcnt_d;
      if (eof) begin
        kstat_q <= kcnt_d;
      end
    end
  end

  assign o_kernel_count = kstat_q;
`endif

endmodule
